// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream: streaming 2x2 stride-2 RGB max-pool with a half-width line buffer of even-row horizontal maxima
module maxpool_2x2_stream #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 54,
  parameter int IMG_H  = 54
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              relu_ack,
  input  logic [DATA_W-1:0] ReLU_in_R,
  input  logic [DATA_W-1:0] ReLU_in_G,
  input  logic [DATA_W-1:0] ReLU_in_B,
  output logic [DATA_W-1:0] pool_o_R,
  output logic [DATA_W-1:0] pool_o_G,
  output logic [DATA_W-1:0] pool_o_B,
  output logic              pool_ack,
  output logic              frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LD = IMG_W / 2;
  localparam int LW = LD > 1 ? $clog2(LD) : 1;
  typedef enum logic {EVEN_ROW, ODD_ROW} state_t;
  state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [LW-1:0] lb_idx;
  logic [3*DATA_W-1:0] linebuf [LD];
  logic [2:0][DATA_W-1:0] in_v, h_reg, hmax, lb_v, pmax;
  logic last_col, last_row;
  assign in_v = {ReLU_in_R, ReLU_in_G, ReLU_in_B};
  assign lb_idx = LW'(col >> 1);
  assign lb_v = linebuf[lb_idx];
  assign last_col = col == CW'(IMG_W - 1);
  assign last_row = row == RW'(IMG_H - 1);
  for (genvar c = 0; c < 3; c++) begin : g_ch
    assign hmax[c] = in_v[c] > h_reg[c] ? in_v[c] : h_reg[c];
    assign pmax[c] = lb_v[c] > hmax[c] ? lb_v[c] : hmax[c];
  end
  always_ff @(posedge clk)
    if (!rst && relu_ack && col[0] && state == EVEN_ROW) linebuf[lb_idx] <= hmax;
  always_ff @(posedge clk) begin
    if (rst) begin
      {pool_o_R, pool_o_G, pool_o_B} <= '0;
      pool_ack <= 1'b0;
      frame_done <= 1'b0;
      col <= '0;
      row <= '0;
      state <= EVEN_ROW;
    end else begin
      pool_ack <= 1'b0;
      frame_done <= 1'b0;
      if (relu_ack) begin
        if (!col[0]) h_reg <= in_v;
        if (col[0] && state == ODD_ROW) begin
          {pool_o_R, pool_o_G, pool_o_B} <= pmax;
          pool_ack <= 1'b1;
          frame_done <= last_col && last_row;
        end
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) begin
          row <= last_row ? '0 : row + 1'b1;
          state <= state == EVEN_ROW ? ODD_ROW : EVEN_ROW;
        end
      end
    end
  end
endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// tb_maxpool_2x2_stream: directed frames on a 4x4 image, scoreboard of expected pooled pixels with arrival cycle
module tb_maxpool_2x2_stream;
  localparam int W = 16;
  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic fd;
    int due;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, relu_ack = 1'b0;
  logic [W-1:0] r_i = '0, g_i = '0, b_i = '0;
  logic [W-1:0] pool_o_R, pool_o_G, pool_o_B;
  logic pool_ack, frame_done;
  exp_t q[$];
  logic [3*W-1:0] img [16];
  logic [3*W-1:0] cur [16];
  logic [3*W-1:0] last = '0;
  int pix = 0, cyc = 0, n_cmp = 0, n_err = 0;

  maxpool_2x2_stream #(.DATA_W(W), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .relu_ack(relu_ack),
    .ReLU_in_R(r_i), .ReLU_in_G(g_i), .ReLU_in_B(b_i),
    .pool_o_R(pool_o_R), .pool_o_G(pool_o_G), .pool_o_B(pool_o_B),
    .pool_ack(pool_ack), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    logic pend;
    if (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      n_cmp++;
      assert (0) else begin n_err++; $error("FAIL missing_out got none exp due cycle %0d", e.due); end
    end
    pend = q.size() > 0 && q[0].due == cyc;
    n_cmp++;
    assert (pool_ack === pend) else begin n_err++; $error("FAIL ack_timing got %b exp %b cyc %0d", pool_ack, pend, cyc); end
    if (pend) begin
      e = q.pop_front();
      last = {e.r, e.g, e.b};
      n_cmp++;
      assert ({pool_o_R, pool_o_G, pool_o_B, frame_done} === {e.r, e.g, e.b, e.fd}) else begin
        n_err++;
        $error("FAIL pool_out got %h/%h/%h fd=%b exp %h/%h/%h fd=%b", pool_o_R, pool_o_G, pool_o_B, frame_done, e.r, e.g, e.b, e.fd);
      end
    end else begin
      n_cmp++;
      assert ({pool_o_R, pool_o_G, pool_o_B, frame_done} === {last, 1'b0}) else begin
        n_err++;
        $error("FAIL hold got %h/%h/%h fd=%b exp %h fd=0", pool_o_R, pool_o_G, pool_o_B, frame_done, last);
      end
    end
    if (rst) last = '0;
  end

  function automatic logic [W-1:0] mx(input int p, input int ch);
    logic [W-1:0] m;
    m = cur[p][ch*W +: W];
    if (cur[p-1][ch*W +: W] > m) m = cur[p-1][ch*W +: W];
    if (cur[p-4][ch*W +: W] > m) m = cur[p-4][ch*W +: W];
    if (cur[p-5][ch*W +: W] > m) m = cur[p-5][ch*W +: W];
    return m;
  endfunction

  task automatic send(input logic [3*W-1:0] v, input int gap);
    exp_t e;
    {r_i, g_i, b_i} = v;
    relu_ack = 1'b1;
    @(posedge clk);
    #1;
    relu_ack = 1'b0;
    cur[pix] = v;
    if ((pix / 4) % 2 == 1 && (pix % 4) % 2 == 1) begin
      e.r = mx(pix, 2);
      e.g = mx(pix, 1);
      e.b = mx(pix, 0);
      e.fd = pix == 15;
      e.due = cyc;
      q.push_back(e);
    end
    pix = (pix + 1) % 16;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < 16; i++) send(img[i], gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    relu_ack = 1'b1;
    {r_i, g_i, b_i} = '1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    relu_ack = 1'b0;
    pix = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    do_reset();
    idle(2);
    for (int i = 0; i < 16; i++) img[i] = {3{W'(i)}};
    send_frame(0);
    idle(3);
    send_frame(3);
    idle(3);
    for (int i = 0; i < 16; i++) img[i] = {3{W'(1)}};
    img[0][3*W-1 -: W] = W'(100);
    img[1][2*W-1 -: W] = W'(200);
    img[4][W-1:0] = W'(300);
    send_frame(1);
    idle(2);
    for (int i = 0; i < 16; i++) img[i] = {3{16'h7FFF}};
    send_frame(0);
    img[5] = {3{16'hFFFF}};
    send_frame(2);
    idle(2);
    for (int i = 0; i < 6; i++) send({W'($urandom), W'($urandom), W'($urandom)}, 0);
    do_reset();
    for (int i = 0; i < 16; i++) img[i] = {W'($urandom), W'($urandom), W'($urandom)};
    send_frame(0);
    idle(2);
    send_frame(0);
    for (int i = 0; i < 16; i++) img[i] = {W'($urandom), W'($urandom), W'($urandom)};
    send_frame(0);
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
